// File: rtl/divider_seq_pkg.sv
// divider_seq_pkg: shared state encoding and iteration count for the sequential divider
package divider_seq_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;
  localparam int DIV_ITERS = 32;
endpackage

// File: rtl/divider_seq_step.sv
// div_step: one restoring-division iteration (shift in a dividend bit, trial subtract)
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);
  logic [WIDTH:0] shifted;
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = shifted >= {1'b0, dvs_i};
    rem_o   = q_o ? WIDTH'(shifted - {1'b0, dvs_i}) : WIDTH'(shifted);
  end
endmodule

// File: rtl/divider_seq.sv
// divider_seq: multi-cycle radix-2 restoring DIV/DIVU with fixed 33-cycle latency,
// sign correction, divide-by-zero convention and cancel for exception flush
module divider_seq
  import divider_seq_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             sign,
  input  logic             cancel,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  div_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_mag, b_mag, rem_n, hi_c, lo_c;
  logic sign_q, sign_d, q_bit, div0;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(rem_n),
    .q_o  (q_bit)
  );

  // Unsigned negation of 0x80000000 yields 0x80000000, the correct magnitude
  always_comb begin
    a_mag = (sign && srca[WIDTH-1]) ? -srca : srca;
    b_mag = (sign && srcb[WIDTH-1]) ? -srcb : srcb;
    div0  = b_q == '0;
    lo_c  = div0 ? '1 : (sign_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_q : quo_q;
    hi_c  = div0 ? a_q : (sign_q && a_q[WIDTH-1]) ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    b_d     = b_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (cancel) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        DIV_IDLE: if (in_valid) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          a_d     = srca;
          b_d     = srcb;
          sign_d  = sign;
        end
        DIV_BUSY: begin
          rem_d   = rem_n;
          quo_d   = {quo_q[WIDTH-2:0], q_bit};
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q == CW'(DIV_ITERS - 1)) ? DIV_DONE : DIV_BUSY;
        end
        default: begin
          state_d = DIV_IDLE;
          hi_d    = hi_c;
          lo_d    = lo_c;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign out_valid = state_q == DIV_DONE;
  assign hi        = out_valid ? hi_c : hi_q;
  assign lo        = out_valid ? lo_c : lo_q;
endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: scoreboard bench for divider_seq; expected results come from a
// 64-bit arithmetic model and are checked with latency when out_valid pulses
module tb_divider_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        sign = 1'b0;
  logic        cancel = 1'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic        out_valid;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic        prev_ov = 1'b0;
  logic [31:0] last_lo = '0;
  logic [31:0] last_hi = '0;

  divider_seq dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .sign     (sign),
    .cancel   (cancel),
    .srca     (srca),
    .srcb     (srcb),
    .out_valid(out_valid),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    longint x, y;
    if (b == 32'd0) begin
      q = '1;
      r = a;
    end else begin
      x = s ? longint'($signed(a)) : longint'({32'd0, a});
      y = s ? longint'($signed(b)) : longint'({32'd0, b});
      q = 32'(x / y);
      r = 32'(x % y);
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (prev_ov) chk("pulse_width", {31'd0, out_valid}, 32'd0);
      if (out_valid) begin
        if (sb.size() == 0) chk("spurious_valid", {31'd0, out_valid}, 32'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("lo", lo, e.lo);
          chk("hi", hi, e.hi);
          chk("latency", 32'(cyc - e.acc), 32'd33);
          last_lo = e.lo;
          last_hi = e.hi;
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s, input bit track);
    exp_t e;
    @(negedge clk);
    srca = a;
    srcb = b;
    sign = s;
    in_valid = 1'b1;
    if (track) begin
      model(a, b, s, e.lo, e.hi);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) begin
      @(negedge clk);
      srca = $urandom;
      srcb = $urandom;
      sign = 1'($urandom);
    end
    chk("drain_timeout", sb.size(), 32'd0);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s);
    start(a, b, s, 1'b1);
    drain();
  endtask

  initial begin
    int   c;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    rst = 1'b1;
    run(32'd100, 32'd7, 1'b0);
    run(-32'sd7, 32'd2, 1'b1);
    run(32'd7, -32'sd2, 1'b1);
    run(-32'sd7, -32'sd2, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run(32'd5, 32'd0, 1'b0);
    run(32'd5, 32'd0, 1'b1);
    run(32'hFFFF_FFFF, 32'd1, 1'b0);
    for (int i = 0; i < 4; i++) run($urandom, $urandom_range(1, 1000), 1'($urandom));
    // back-to-back: in_valid held through DONE, new operands the cycle after
    @(negedge clk);
    srca = 32'd100;
    srcb = 32'd7;
    sign = 1'b0;
    in_valid = 1'b1;
    model(32'd100, 32'd7, 1'b0, e.lo, e.hi);
    e.acc = cyc;
    sb.push_back(e);
    c = cyc;
    repeat (33) begin
      @(negedge clk);
      srca = $urandom;
      srcb = $urandom;
    end
    @(negedge clk);
    chk("b2b_gap", 32'(cyc - c), 32'd34);
    srca = 32'd9;
    srcb = 32'd3;
    model(32'd9, 32'd3, 1'b0, e.lo, e.hi);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    // cancel at cycle 10 of an untracked request
    c = cyc;
    start(32'd50, 32'd6, 1'b0, 1'b0);
    while (cyc < c + 10) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    repeat (40) @(negedge clk);
    chk("cancel_lo", lo, last_lo);
    chk("cancel_hi", hi, last_hi);
    // reset at cycle 20, then an immediate new request
    c = cyc;
    start(32'd50, 32'd6, 1'b0, 1'b0);
    while (cyc < c + 20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_hi", hi, 32'd0);
    chk("midrst_lo", lo, 32'd0);
    srca = 32'd100;
    srcb = 32'd7;
    sign = 1'b0;
    in_valid = 1'b1;
    model(32'd100, 32'd7, 1'b0, e.lo, e.hi);
    e.acc = cyc;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
